// File: rtl/modexp_engine_pkg.sv
// Shared definitions for the modular exponentiation engine.
//   state_t    : engine FSM encoding
//   lat_cycles : fixed start-to-done latency of a normal run for a given
//                operand width (two serial multiplies of W+1 cycles per
//                exponent bit, plus LOAD and FIN)
package modexp_engine_pkg;

    // STEP exists in the encoding for documentation only: the bit-index
    // decrement happens in the final cycle of MUL, so STEP is never entered.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SQR,
        ST_MUL,
        ST_STEP,
        ST_FIN
    } state_t;

    function automatic int unsigned lat_cycles(input int unsigned w);
        return 2 * w * (w + 1) + 2;
    endfunction

endpackage

// File: rtl/modmul_serial.sv
// Bit-serial Blakley modular multiplier: p = a*b mod n, MSB-first.
// Requires a < n and b < n; the running product then always stays below n.
//   clk, rst_n : clock, asynchronous active-low reset
//   mm_start   : latch a/b/n and clear the product (accepted at any time)
//   a, b, n    : multiplicand, multiplier, modulus
//   p          : product, valid while mm_done is high
//   mm_done    : one-cycle pulse, W+1 cycles after the mm_start cycle
module modmul_serial #(
    parameter int RSA_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mm_start,
    input  logic [RSA_WIDTH-1:0] a,
    input  logic [RSA_WIDTH-1:0] b,
    input  logic [RSA_WIDTH-1:0] n,
    output logic [RSA_WIDTH-1:0] p,
    output logic                 mm_done
);

    localparam int W  = RSA_WIDTH;
    localparam int IW = $clog2(W);

    logic [W-1:0]  a_q, b_q, n_q, p_q;
    logic [IW-1:0] j_q;
    logic          busy_q;
    logic          done_q;

    logic [W:0]    dbl, dbl_red, acc;
    logic [W-1:0]  p_next;

    // One Blakley step: double, reduce, conditionally add b, reduce.
    // Both intermediates stay below 2n, so W+1 bits and one subtract suffice.
    always_comb begin
        dbl     = {p_q, 1'b0};
        dbl_red = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
        acc     = dbl_red + (a_q[j_q] ? {1'b0, b_q} : '0);
        p_next  = (acc >= {1'b0, n_q}) ? W'(acc - {1'b0, n_q}) : W'(acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            p_q    <= '0;
            j_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: the pulse defaults low here and is raised only below, so it can never stick high.
            done_q <= 1'b0;
            if (mm_start) begin
                a_q    <= a;
                b_q    <= b;
                n_q    <= n;
                p_q    <= '0;
                j_q    <= IW'(W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                p_q <= p_next;
                if (j_q == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    j_q <= j_q - 1'b1;
                end
            end
        end
    end

    assign p       = p_q;
    assign mm_done = done_q;

endmodule

// File: rtl/modexp_engine.sv
// Constant-time modular exponentiation c = m^e mod n (left-to-right binary).
// Every exponent bit costs one square and one multiply; the multiply result
// is kept or discarded by e[i], so timing and activity do not depend on e.
//   S_AXI_ACLK, S_AXI_ARESETN : clock, asynchronous active-low reset
//   start    : request, accepted only while ready=1
//   m, e, n  : base, exponent, modulus, latched on the accepted start
//   c        : result, held from done until the next accepted start
//   ready    : idle, able to accept start
//   done     : one-cycle pulse when c/err are valid
//   err      : operand error (n<2 or m>=n) on the last run
module modexp_engine
    import modexp_engine_pkg::*;
#(
    parameter int RSA_WIDTH = 128
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 start,
    input  logic [RSA_WIDTH-1:0] m,
    input  logic [RSA_WIDTH-1:0] e,
    input  logic [RSA_WIDTH-1:0] n,
    output logic [RSA_WIDTH-1:0] c,
    output logic                 ready,
    output logic                 done,
    output logic                 err
);

    localparam int          W   = RSA_WIDTH;
    localparam int          IW  = $clog2(W);
    localparam int unsigned LAT = lat_cycles(RSA_WIDTH);
    localparam int          CW  = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAT_V = CW'(LAT);

    state_t        state, state_nxt;
    logic [W-1:0]  m_q, e_q, n_q, r_q;
    logic [IW-1:0] i_q;
    logic [CW-1:0] cnt_q;

    logic          mm_start, mm_done;
    logic [W-1:0]  mm_a, mm_b, p;
    logic [W-1:0]  r_new;
    logic          operand_bad;
    logic          timeout;

    // Value R takes when the current multiply completes: squares always
    // land, multiplies land only for a set exponent bit.
    assign r_new       = (state == ST_MUL && !e_q[i_q]) ? r_q : p;
    assign operand_bad = (n_q < W'(2)) || (m_q >= n_q);
    // Safety net: a run still multiplying at LAT cycles is forced to an error.
    assign timeout     = (state inside {ST_SQR, ST_MUL}) && (cnt_q >= LAT_V);
    assign ready       = (state == ST_IDLE);
    assign done        = (state == ST_FIN);

    modmul_serial #(.RSA_WIDTH(W)) u_mul (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .mm_start (mm_start),
        .a        (mm_a),
        .b        (mm_b),
        .n        (n_q),
        .p        (p),
        .mm_done  (mm_done)
    );

    // The next multiply is launched in the completion cycle of the previous
    // one, with R forwarded from the multiplier output, so each multiply
    // occupies exactly W+1 cycles of its state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        mm_start  = 1'b0;
        mm_a      = r_new;
        mm_b      = r_new;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (operand_bad) begin
                    state_nxt = ST_FIN;
                end else begin
                    mm_start  = 1'b1;
                    mm_a      = W'(1);
                    mm_b      = W'(1);
                    state_nxt = ST_SQR;
                end
            end
            ST_SQR: begin
                if (mm_done) begin
                    mm_start  = 1'b1;
                    mm_a      = p;
                    mm_b      = m_q;
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mm_done) begin
                    if (i_q == '0) begin
                        state_nxt = ST_FIN;
                    end else begin
                        mm_start  = 1'b1;
                        state_nxt = ST_SQR;
                    end
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (timeout) begin
            state_nxt = ST_FIN;
            mm_start  = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= ST_IDLE;
            m_q   <= '0;
            e_q   <= '0;
            n_q   <= '0;
            r_q   <= '0;
            i_q   <= '0;
            cnt_q <= '0;
            c     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_IDLE && start) begin
                cnt_q <= CW'(1);
            end else if (state inside {ST_LOAD, ST_SQR, ST_MUL}) begin
                cnt_q <= cnt_q + CW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_q <= m;
                        e_q <= e;
                        n_q <= n;
                    end
                end
                ST_LOAD: begin
                    err <= operand_bad;
                    if (operand_bad) begin
                        c <= '0;
                    end else begin
                        r_q <= W'(1);
                        i_q <= IW'(W - 1);
                    end
                end
                ST_SQR: if (mm_done) r_q <= r_new;
                ST_MUL: begin
                    if (mm_done) begin
                        r_q <= r_new;
                        if (i_q == '0) begin
                            c   <= r_new;
                            err <= 1'b0;
                        end else begin
                            i_q <= i_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (timeout) begin
                c   <= '0;
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modexp_engine.sv
// Self-checking bench for modexp_engine: one 16-bit and one 8-bit instance.
// Expected results come from a repeated-multiplication model of m^e mod n.
module tb_modexp_engine;
    import modexp_engine_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start16;
    logic [15:0] m16, e16, n16, c16;
    logic        ready16, done16, err16;
    logic        start8;
    logic [7:0]  m8, e8, n8, c8;
    logic        ready8, done8, err8;

    modexp_engine #(.RSA_WIDTH(16)) dut16 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start16),
        .m(m16), .e(e16), .n(n16), .c(c16),
        .ready(ready16), .done(done16), .err(err16)
    );

    modexp_engine #(.RSA_WIDTH(8)) dut8 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start8),
        .m(m8), .e(e8), .n(n8), .c(c8),
        .ready(ready8), .done(done8), .err(err8)
    );

    typedef struct {
        bit          w8;
        logic [15:0] m, e, n;
        longint      exp_c;
        bit          exp_err;
        int          exp_lat;
        string       name;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // m^e mod n by e repeated multiplications; error when n<2 or m>=n.
    function automatic void ref_model(input longint mm, input longint ee, input longint nn,
                                      output longint cc, output bit er);
        er = (nn < 2) || (mm >= nn);
        cc = 0;
        if (!er) begin
            cc = 1 % nn;
            for (longint k = 0; k < ee; k++) cc = (cc * mm) % nn;
        end
    endfunction

    function automatic vec_t mk(input bit w8, input logic [15:0] mi, input logic [15:0] ei,
                                input logic [15:0] ni, input longint cc, input bit er,
                                input int lat, input string name);
        vec_t v;
        v.w8 = w8; v.m = mi; v.e = ei; v.n = ni;
        v.exp_c = cc; v.exp_err = er; v.exp_lat = lat; v.name = name;
        return v;
    endfunction

    task automatic drive(input bit w8, input bit st, input logic [15:0] mi,
                         input logic [15:0] ei, input logic [15:0] ni);
        if (w8) begin
            start8 = st; m8 = mi[7:0]; e8 = ei[7:0]; n8 = ni[7:0];
        end else begin
            start16 = st; m16 = mi; e16 = ei; n16 = ni;
        end
    endtask

    task automatic sample(input bit w8, output logic [15:0] cv, output logic rd,
                          output logic dn, output logic er);
        cv = w8 ? {8'h00, c8} : c16;
        rd = w8 ? ready8 : ready16;
        dn = w8 ? done8  : done16;
        er = w8 ? err8   : err16;
    endtask

    // Issue one start, count cycles to done (cycle 1 is the one right after
    // the accepting edge). Optionally pulse extra starts at inj_a/inj_b, or
    // assert reset at rst_at instead of waiting for done.
    task automatic run_op(input bit w8, input logic [15:0] mi, input logic [15:0] ei,
                          input logic [15:0] ni, input longint exp_c, input bit exp_err,
                          input int exp_lat, input string name,
                          input int inj_a, input int inj_b, input int rst_at);
        int          bound, cyc, got;
        bit          fin;
        logic [15:0] cv;
        logic        rd, dn, er;
        bound = int'(lat_cycles(w8 ? 8 : 16)) + 50;
        @(negedge clk);
        drive(w8, 1'b1, mi, ei, ni);
        @(posedge clk);
        cyc = 0; got = 0; fin = 0;
        while (!fin && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                drive(w8, 1'b0, mi, ei, ni);
                sample(w8, cv, rd, dn, er);
                check({name, " ready low"}, longint'(rd), 0);
            end
            if ((inj_a > 0 && cyc == inj_a) || (inj_b > 0 && cyc == inj_b))
                drive(w8, 1'b1, 16'h0012, 16'hffff, 16'h7fff);
            else if ((inj_a > 0 && cyc == inj_a + 1) || (inj_b > 0 && cyc == inj_b + 1))
                drive(w8, 1'b0, 16'h0012, 16'hffff, 16'h7fff);
            sample(w8, cv, rd, dn, er);
            if (dn) begin
                got = cyc;
                fin = 1;
            end else if (rst_at > 0 && cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                sample(w8, cv, rd, dn, er);
                check({name, " c in reset"}, longint'(cv), 0);
                check({name, " ready in reset"}, longint'(rd), 1);
                check({name, " done in reset"}, longint'(dn), 0);
                check({name, " err in reset"}, longint'(er), 0);
                @(negedge clk);
                rst_n = 1'b1;
                fin = 1;
            end
        end
        if (rst_at > 0) begin
            check({name, " no done before reset"}, got, 0);
        end else begin
            check({name, " latency"}, got, exp_lat);
            if (got != 0) begin
                check({name, " c"}, longint'(cv), exp_c);
                check({name, " err"}, longint'(er), longint'(exp_err));
                @(negedge clk);
                sample(w8, cv, rd, dn, er);
                check({name, " ready after"}, longint'(rd), 1);
                check({name, " done pulse"}, longint'(dn), 0);
                check({name, " c held"}, longint'(cv), exp_c);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        longint      mc;
        bit          me;
        logic [15:0] cv;
        logic        rd, dn, er;
        logic [15:0] rm, re, rn;

        drive(1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample(w[0], cv, rd, dn, er);
            check("reset c", longint'(cv), 0);
            check("reset ready", longint'(rd), 1);
            check("reset done", longint'(dn), 0);
            check("reset err", longint'(er), 0);
        end

        ref_model(4, 16'h8001, 497, mc, me);
        vecs[0] = mk(0, 65, 17, 3233, 2790, 0, 546, "w16 rsa");
        vecs[1] = mk(0, 4, 13, 497, 445, 0, 546, "w16 4^13");
        vecs[2] = mk(0, 4, 16'h8001, 497, mc, 0, 546, "w16 e=0x8001");
        vecs[3] = mk(0, 16'h00ff, 3, 16'h0100, 255, 0, 546, "w16 m=n-1");
        vecs[4] = mk(1, 7, 0, 11, 1, 0, 146, "w8 e=0");
        vecs[5] = mk(1, 12, 3, 11, 0, 1, 2, "w8 m>=n");
        vecs[6] = mk(1, 9, 1, 11, 9, 0, 146, "w8 e=1");
        vecs[7] = mk(1, 5, 3, 1, 0, 1, 2, "w8 n=1");
        vecs[8] = mk(1, 0, 5, 11, 0, 0, 146, "w8 m=0");
        vecs[9] = mk(1, 254, 255, 255, 254, 0, 146, "w8 max");

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].w8, vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].exp_c,
                   vecs[i].exp_err, vecs[i].exp_lat, vecs[i].name, 0, 0, 0);

        // Starts while busy must be ignored; result comes from the first operands.
        run_op(0, 65, 17, 3233, 2790, 0, 546, "w16 busy starts", 10, 300, 0);
        // Reset mid-run aborts without done; a fresh run then completes normally.
        run_op(0, 65, 17, 3233, 0, 0, 0, "w16 abort", 0, 0, 200);
        run_op(0, 65, 17, 3233, 2790, 0, 546, "w16 after reset", 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            rn = 16'($urandom_range(2, 65535));
            rm = 16'($urandom_range(0, int'(rn) - 1));
            re = 16'($urandom_range(0, 65535));
            ref_model(longint'(rm), longint'(re), longint'(rn), mc, me);
            run_op(0, rm, re, rn, mc, me, me ? 2 : 546, "w16 random", 0, 0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            rn = 16'($urandom_range(0, 255));
            rm = 16'($urandom_range(0, 255));
            re = 16'($urandom_range(0, 255));
            ref_model(longint'(rm), longint'(re), longint'(rn), mc, me);
            run_op(1, rm, re, rn, mc, me, me ? 2 : 146, "w8 random", 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
